rx_module: RTL and testbench
============================

RX_MODULE -- requirements
Module: rx_module

Interface
REQ-001 Parameter MAX_UART_DATA_W, default 8: maximum received data width.
REQ-002 Parameter STOP_CONF_W, default 2: stop-bit configuration field width.
REQ-003 Parameter DATA_CONF_W, default 2: data-bit configuration field width.
REQ-004 Parameter SAMPLE_COUNT_W, default 4: oversample counter width (16 samples per bit).
REQ-005 Parameter DATA_COUNTER_W, default 3: data bit index counter width.
REQ-006 Parameter TOTAL_CONF_W, default STOP_CONF_W+DATA_CONF_W+1: configuration bus width.
REQ-007 clk_i  input  1  sole clock, rising edge.
REQ-008 rst_ni  input  1  asynchronous active-low reset.
REQ-009 baud_en_i  input  1  16x oversample tick, one clk_i wide; all FSM/counter advancement gated by it.
REQ-010 rx_en_i  input  1  receiver enable.
REQ-011 rx_conf_i  input  TOTAL_CONF_W  {data[1:0], stop[1:0], parity_en}; data bits = 5+data, stop bits = 1+stop.
REQ-012 rx_fifo_en_i  input  1  enables FIFO push generation.
REQ-013 uart_rx_i  input  1  external asynchronous serial input, idle high.
REQ-014 rx_data_o  output  MAX_UART_DATA_W  last received character, LSB first on line, unused MSBs zero.
REQ-015 rx_done_o  output  1  single clk_i pulse at end of each character.
REQ-016 rx_busy_o  output  1  high from start-bit validation through last stop bit.
REQ-017 rx_parity_err_o  output  1  even-parity mismatch of last character.
REQ-018 rx_frame_err_o  output  1  any stop bit sampled low in last character.
REQ-019 rx_fifo_push_o  output  1  push strobe to Rx FIFO.

Function
REQ-020 uart_rx_i SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-021 FSM states: Reset, Idle, RecvStart, RecvData, RecvParity, RecvStop, Done; transitions only on baud_en_i.
REQ-022 Reset->Idle when rx_en_i=1; Idle->RecvStart on tick with synced line=0; sample counter cleared to 0 on entry.
REQ-023 rx_conf_i SHALL be latched on the Idle->RecvStart transition and held for the frame.
REQ-024 Each bit state: counter increments per tick, wraps 15->0; bit sampled at count 7; state advances at count 15.
REQ-025 RecvStart: sample=1 at count 7 is a false start -> Idle, no done, no output change.
REQ-026 RecvData: bit written to index data_counter; after 5+data bits -> RecvParity if parity_en else RecvStop.
REQ-027 RecvParity: error = sampled bit != XOR of received data bits (even parity).
REQ-028 RecvStop: 1+stop bits sampled; any 0 sets frame error; then -> Done.
REQ-029 Done (one tick): rx_data_o, rx_parity_err_o, rx_frame_err_o updated; rx_done_o pulses one clk_i; -> Idle if rx_en_i else Reset.
REQ-030 rx_parity_err_o SHALL be 0 for frames with parity_en=0.
REQ-031 rx_fifo_push_o = rx_done_o AND rx_fifo_en_i AND NOT frame error.
REQ-032 rx_en_i deasserted mid-frame SHALL NOT abort; frame completes, then Reset.
REQ-033 rx_data_o and error flags SHALL hold between Done states; false starts never alter them.
REQ-034 rx_busy_o rises on RecvStart->RecvData and falls on entry to Done.

Reset
REQ-035 rst_ni low SHALL immediately force state Reset, all counters 0, synchronizer 1, all outputs 0, regardless of frame in progress.
REQ-036 After rst_ni release, reception starts only after a fresh falling edge in Idle.

Configuration
REQ-037 Macro RX_MAJORITY_VOTE_EN defined: each bit value = 2-of-3 majority of samples at counts 6, 7, 8; decision applied at count 8.
REQ-038 Macro undefined: single sample at count 7, no vote logic synthesized; all other behaviour identical.

Verification
REQ-039 baud_en_i=1 every clk, conf=5'b11000, send 8N1 0xA5 -> rx_data_o=0xA5, one rx_done_o pulse, both errors 0.
REQ-040 conf=5'b10001 (7E1), send 0x35 with parity bit 1 (wrong) -> rx_data_o=0x35, rx_parity_err_o=1.
REQ-041 conf=5'b11010 (8N2), second stop bit driven 0 -> rx_frame_err_o=1, rx_fifo_push_o stays 0 with rx_fifo_en_i=1.
REQ-042 4-tick low glitch in Idle -> no rx_done_o, rx_busy_o stays 0, rx_data_o unchanged.
REQ-043 rst_ni pulsed low during RecvData of 0x5A -> outputs 0 at once; following 0x3C received correctly.
REQ-044 With RX_MAJORITY_VOTE_EN, single-sample glitch at count 7 of each data bit of 0xC3 -> rx_data_o=0xC3; without macro, corrupted value observed.

Source files
------------

// File: rtl/rx_module_if.sv
// rx_module_if: result/handshake bundle between the UART receiver and the
// block that consumes received characters (typically an Rx FIFO).
// master = receiver side, slave = consumer side.
interface rx_module_if #(
  parameter int MAX_UART_DATA_W = 8
);
  logic [MAX_UART_DATA_W-1:0] rx_data_o;
  logic                       rx_done_o;
  logic                       rx_busy_o;
  logic                       rx_parity_err_o;
  logic                       rx_frame_err_o;
  logic                       rx_fifo_push_o;
  logic                       rx_fifo_en_i;

  modport master (
    output rx_data_o,
    output rx_done_o,
    output rx_busy_o,
    output rx_parity_err_o,
    output rx_frame_err_o,
    output rx_fifo_push_o,
    input  rx_fifo_en_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_done_o,
    input  rx_busy_o,
    input  rx_parity_err_o,
    input  rx_frame_err_o,
    input  rx_fifo_push_o,
    output rx_fifo_en_i
  );
endinterface

// File: rtl/rx_module.sv
// rx_module: UART receiver, 16x oversampled, 5..8 data bits, optional even
// parity, 1..4 stop bits. Configuration is latched at the start of each frame.
// Optional build macro RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority of
// the samples taken at counts 6, 7 and 8 (decision at count 8). Without it a
// single sample at count 7 is used.
module rx_module #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int STOP_CONF_W     = 2,
  parameter int DATA_CONF_W     = 2,
  parameter int SAMPLE_COUNT_W  = 4,
  parameter int DATA_COUNTER_W  = 3,
  parameter int TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    baud_en_i,
  input  logic                    rx_en_i,
  input  logic [TOTAL_CONF_W-1:0] rx_conf_i,
  input  logic                    uart_rx_i,
  rx_module_if.master             rx_bus
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // Line synchronizer; rx_line is the only view of the serial input used below.
  logic [1:0] sync_q;
  logic       rx_line;

  // Control state
  logic [SAMPLE_COUNT_W-1:0] sample_cnt_q;
  logic [DATA_COUNTER_W-1:0] bit_cnt_q;
  logic [TOTAL_CONF_W-1:0]   conf_q;
  logic                      armed_q;
  logic                      busy_q;
  logic                      done_q;
  logic [MAX_UART_DATA_W-1:0] data_q;
  logic                      par_err_q;
  logic                      frame_err_q;

  // Per-frame working data
  logic [MAX_UART_DATA_W-1:0] shift_q;
  logic                       par_acc_q;
  logic                       frame_acc_q;

  // Decoded frame configuration (from the latched copy)
  logic [DATA_CONF_W-1:0]    conf_data;
  logic [STOP_CONF_W-1:0]    conf_stop;
  logic                      conf_parity;

  logic in_bit_state;
  logic sample_pt;
  logic bit_end;
  logic bit_val;
  logic last_data_bit;
  logic last_stop_bit;
  logic start_frame;

  assign rx_line     = sync_q[1];
  assign conf_data   = conf_q[TOTAL_CONF_W-1 -: DATA_CONF_W];
  assign conf_stop   = conf_q[STOP_CONF_W:1];
  assign conf_parity = conf_q[0];

  assign in_bit_state  = (state_q == ST_START) || (state_q == ST_DATA) ||
                         (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign bit_end       = (sample_cnt_q == {SAMPLE_COUNT_W{1'b1}});
  assign last_data_bit = (bit_cnt_q == (DATA_COUNTER_W'(4) + DATA_COUNTER_W'(conf_data)));
  assign last_stop_bit = (bit_cnt_q == DATA_COUNTER_W'(conf_stop));
  assign start_frame   = baud_en_i && (state_q == ST_IDLE) && (state_d == ST_START);

`ifdef RX_MAJORITY_VOTE_EN
  logic samp6_q;
  logic samp7_q;

  assign sample_pt = (sample_cnt_q == SAMPLE_COUNT_W'(8));
  assign bit_val   = (samp6_q & samp7_q) | (samp6_q & rx_line) | (samp7_q & rx_line);

  // Capture the two early votes; the third is the live line at count 8.
  always_ff @(posedge clk_i) begin
    if (baud_en_i && in_bit_state) begin
      if (sample_cnt_q == SAMPLE_COUNT_W'(6)) samp6_q <= rx_line;
      if (sample_cnt_q == SAMPLE_COUNT_W'(7)) samp7_q <= rx_line;
    end
  end
`else
  assign sample_pt = (sample_cnt_q == SAMPLE_COUNT_W'(7));
  assign bit_val   = rx_line;
`endif

  // Two-flop synchronizer for the asynchronous serial line, idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
    end
  end

  // Next-state logic; every transition waits for an oversample tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: begin
        if (baud_en_i && rx_en_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // armed_q demands the line was seen high first, so a line that is
        // already low (e.g. after reset mid-frame) cannot start a frame.
        if (baud_en_i && armed_q && !rx_line) state_d = ST_START;
      end
      ST_START: begin
        if (baud_en_i) begin
          if (sample_pt && bit_val) state_d = ST_IDLE;
          else if (bit_end)         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_en_i && bit_end && last_data_bit) begin
          state_d = conf_parity ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (baud_en_i && bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (baud_en_i && bit_end && last_stop_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (baud_en_i) state_d = rx_en_i ? ST_IDLE : ST_RESET;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // State register, counters, latched config and the architectural outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RESET;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      conf_q       <= '0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (start_frame) begin
        armed_q <= 1'b0;
      end else if (rx_line && ((state_q == ST_RESET) || (state_q == ST_IDLE) ||
                               (state_q == ST_STOP))) begin
        armed_q <= 1'b1;
      end

      if (baud_en_i) begin
        state_q <= state_d;

        // Counter wraps 15->0 naturally at each bit boundary; a false start
        // or leaving the bit states clears it.
        if (in_bit_state && (state_d != ST_IDLE)) begin
          sample_cnt_q <= sample_cnt_q + SAMPLE_COUNT_W'(1);
        end else begin
          sample_cnt_q <= '0;
        end

        if (start_frame) begin
          bit_cnt_q <= '0;
          conf_q    <= rx_conf_i;
        end else if (((state_q == ST_DATA) || (state_q == ST_STOP)) && bit_end) begin
          bit_cnt_q <= (state_d != state_q) ? '0 : bit_cnt_q + DATA_COUNTER_W'(1);
        end

        if ((state_q == ST_START) && (state_d == ST_DATA)) begin
          busy_q <= 1'b1;
        end else if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
          busy_q <= 1'b0;
        end

        if (state_q == ST_DONE) begin
          done_q      <= 1'b1;
          data_q      <= shift_q;
          par_err_q   <= par_acc_q;
          frame_err_q <= frame_acc_q;
        end
      end
    end
  end

  // Frame assembly: data bits, parity check and stop-bit check.
  always_ff @(posedge clk_i) begin
    if (start_frame) begin
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      frame_acc_q <= 1'b0;
    end else if (baud_en_i && sample_pt) begin
      case (state_q)
        ST_DATA:   shift_q[bit_cnt_q] <= bit_val;
        ST_PARITY: par_acc_q <= bit_val ^ (^shift_q);
        ST_STOP:   if (!bit_val) frame_acc_q <= 1'b1;
        default:   ;
      endcase
    end
  end

  assign rx_bus.rx_data_o       = data_q;
  assign rx_bus.rx_done_o       = done_q;
  assign rx_bus.rx_busy_o       = busy_q;
  assign rx_bus.rx_parity_err_o = par_err_q;
  assign rx_bus.rx_frame_err_o  = frame_err_q;
  assign rx_bus.rx_fifo_push_o  = done_q & rx_bus.rx_fifo_en_i & ~frame_err_q;

endmodule

// File: tb/tb_rx_module.sv
// tb_rx_module: directed bench for rx_module. Frames are bit-banged on
// uart_rx_i with baud_en_i high every clock (16 clocks per bit); expected
// characters are queued when sent and checked when rx_done_o pulses.
`timescale 1ns/1ps
module tb_rx_module;
  localparam int W = 8;

  logic       clk_i     = 1'b0;
  logic       rst_ni    = 1'b0;
  logic       baud_en_i = 1'b1;
  logic       rx_en_i   = 1'b0;
  logic       uart_rx_i = 1'b1;
  logic [4:0] rx_conf_i = 5'b11000;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int n_before = 0;
  bit busy_seen = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_e;
  logic [7:0] last_data = 8'h00;
  logic [7:0] vote_exp;

  rx_module_if #(.MAX_UART_DATA_W(W)) rx_bus();

  rx_module #(.MAX_UART_DATA_W(W)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .baud_en_i (baud_en_i),
    .rx_en_i   (rx_en_i),
    .rx_conf_i (rx_conf_i),
    .uart_rx_i (uart_rx_i),
    .rx_bus    (rx_bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // One bit time; with glitch the line is inverted for the single clock
  // that lands on the count-7 sample.
  task automatic hold_bit(input logic b, input bit glitch);
    uart_rx_i = b;
    if (glitch) begin
      wait_clk(8);
      uart_rx_i = ~b;
      wait_clk(1);
      uart_rx_i = b;
      wait_clk(7);
    end else begin
      wait_clk(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                            input logic par_bit, input int nstop, input logic [3:0] stop_vals,
                            input bit glitch, input logic [4:0] mid_conf, input bit drop_en);
    busy_seen = 1'b0;
    hold_bit(1'b0, 1'b0);
    rx_conf_i = mid_conf;
    if (drop_en) rx_en_i = 1'b0;
    for (int i = 0; i < nbits; i++) hold_bit(data[i], glitch);
    if (par_en) hold_bit(par_bit, 1'b0);
    for (int i = 0; i < nstop; i++) hold_bit(stop_vals[i], 1'b0);
    uart_rx_i = 1'b1;
    wait_clk(24);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
    exp_q.push_back({ferr, perr, d});
    last_data = d;
  endtask

  task automatic frame_done(input string tag, input int cnt_before);
    check({tag, "_done_count"}, done_cnt, cnt_before + 1);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_busy_seen"}, busy_seen, 1);
    check({tag, "_busy_after"}, rx_bus.rx_busy_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  rx_bus.rx_data_o, 0);
    check({tag, "_done"},  rx_bus.rx_done_o, 0);
    check({tag, "_busy"},  rx_bus.rx_busy_o, 0);
    check({tag, "_perr"},  rx_bus.rx_parity_err_o, 0);
    check({tag, "_ferr"},  rx_bus.rx_frame_err_o, 0);
    check({tag, "_push"},  rx_bus.rx_fifo_push_o, 0);
  endtask

  // Scoreboard: every done pulse must match the oldest queued character.
  always @(negedge clk_i) begin
    if (rx_bus.rx_busy_o) busy_seen = 1'b1;
    if (rx_bus.rx_done_o) begin
      done_cnt++;
      check("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("rx_data", rx_bus.rx_data_o, exp_e[7:0]);
        check("parity_err", rx_bus.rx_parity_err_o, exp_e[8]);
        check("frame_err", rx_bus.rx_frame_err_o, exp_e[9]);
        check("fifo_push", rx_bus.rx_fifo_push_o, rx_bus.rx_fifo_en_i & ~exp_e[9]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rx_bus.rx_fifo_en_i = 1'b1;
    rst_ni = 1'b0;
    wait_clk(3);
    check_all_zero("reset");
    rst_ni  = 1'b1;
    rx_en_i = 1'b1;
    wait_clk(20);

    // 8N1 0xA5
    rx_conf_i = 5'b11000;
    n_before = done_cnt;
    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 5'b11000, 1'b0);
    frame_done("8n1_a5", n_before);

    // 7E1 0x35 with wrong parity bit (four ones -> even parity bit is 0)
    rx_conf_i = 5'b10001;
    n_before = done_cnt;
    expect_frame(8'h35, 1'b1, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1, 4'b0001, 1'b0, 5'b10001, 1'b0);
    frame_done("7e1_bad", n_before);

    // 7E1 0x35 with correct parity
    n_before = done_cnt;
    expect_frame(8'h35, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1, 4'b0001, 1'b0, 5'b10001, 1'b0);
    frame_done("7e1_good", n_before);

    // 8N2 with second stop bit low: frame error, no push
    rx_conf_i = 5'b11010;
    n_before = done_cnt;
    expect_frame(8'hC7, 1'b0, 1'b1);
    send_frame(8'hC7, 8, 1'b0, 1'b0, 2, 4'b0001, 1'b0, 5'b11010, 1'b0);
    frame_done("8n2_ferr", n_before);
    check("8n2_ferr_held", rx_bus.rx_frame_err_o, 1);
    check("8n2_push_idle", rx_bus.rx_fifo_push_o, 0);

    // 8N1 with FIFO push disabled
    rx_conf_i = 5'b11000;
    rx_bus.rx_fifo_en_i = 1'b0;
    n_before = done_cnt;
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 5'b11000, 1'b0);
    frame_done("fifo_off", n_before);
    rx_bus.rx_fifo_en_i = 1'b1;

    // 5N1 0x15; config changed mid-frame must be ignored
    rx_conf_i = 5'b00000;
    n_before = done_cnt;
    expect_frame(8'h15, 1'b0, 1'b0);
    send_frame(8'h15, 5, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 5'b11010, 1'b0);
    frame_done("5n1_latch", n_before);

    // 4-clock low glitch in Idle: false start
    rx_conf_i = 5'b11000;
    n_before  = done_cnt;
    busy_seen = 1'b0;
    uart_rx_i = 1'b0;
    wait_clk(4);
    uart_rx_i = 1'b1;
    wait_clk(40);
    check("glitch_no_done", done_cnt, n_before);
    check("glitch_no_busy", busy_seen, 0);
    check("glitch_data_held", rx_bus.rx_data_o, last_data);

    // rx_en dropped mid-frame: frame completes, then receiver parks in Reset
    n_before = done_cnt;
    expect_frame(8'h66, 1'b0, 1'b0);
    send_frame(8'h66, 8, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 5'b11000, 1'b1);
    frame_done("en_drop", n_before);
    n_before = done_cnt;
    send_frame(8'h99, 8, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 5'b11000, 1'b0);
    check("disabled_no_done", done_cnt, n_before);
    rx_en_i = 1'b1;
    wait_clk(8);
    n_before = done_cnt;
    expect_frame(8'h42, 1'b0, 1'b0);
    send_frame(8'h42, 8, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 5'b11000, 1'b0);
    frame_done("reenable", n_before);

    // Asynchronous reset during data bits of 0x5A
    hold_bit(1'b0, 1'b0);
    hold_bit(1'b0, 1'b0);
    hold_bit(1'b1, 1'b0);
    wait_clk(5);
    rst_ni = 1'b0;
    #1;
    check_all_zero("midreset");
    uart_rx_i = 1'b1;
    wait_clk(3);
    rst_ni = 1'b1;
    wait_clk(20);
    check("post_reset_no_done", done_cnt, n_before + 1);
    n_before = done_cnt;
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 5'b11000, 1'b0);
    frame_done("after_reset", n_before);

    // Single-clock glitch on the count-7 sample of every data bit of 0xC3
`ifdef RX_MAJORITY_VOTE_EN
    vote_exp = 8'hC3;
`else
    vote_exp = 8'h3C;
`endif
    n_before = done_cnt;
    expect_frame(vote_exp, 1'b0, 1'b0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 4'b0001, 1'b1, 5'b11000, 1'b0);
    frame_done("vote_c3", n_before);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
